// File: rtl/proc_acc_io.sv
// Accumulator processor with an integrated data RAM, index-register addressing,
// handshaked input/output channels and a HALT state. Instruction memory is an
// external combinational ROM addressed by the program counter.
module proc_acc_io #(
   parameter int NBADD = 10,
   parameter int NBITS = 16,
   parameter int NCH   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [NBADD-1:0]       imem_addr,
   input  logic [NBADD+4:0]       imem_data,
   input  logic [NCH*NBITS-1:0]   in_data,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   output logic [NCH*NBITS-1:0]   out_data,
   output logic [NCH-1:0]         out_valid,
   input  logic [NCH-1:0]         out_ready,
   output logic [NBITS-1:0]       acc,
   output logic                   halted
);

   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int DEPTH = 1 << NBADD;

   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_LD   = 5'd2;
   localparam logic [4:0] OP_ST   = 5'd3;
   localparam logic [4:0] OP_ADD  = 5'd4;
   localparam logic [4:0] OP_SUB  = 5'd5;
   localparam logic [4:0] OP_AND  = 5'd6;
   localparam logic [4:0] OP_OR   = 5'd7;
   localparam logic [4:0] OP_XOR  = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_SHR  = 5'd10;
   localparam logic [4:0] OP_JMP  = 5'd11;
   localparam logic [4:0] OP_JZ   = 5'd12;
   localparam logic [4:0] OP_JN   = 5'd13;
   localparam logic [4:0] OP_SETX = 5'd14;
   localparam logic [4:0] OP_INCX = 5'd15;
   localparam logic [4:0] OP_IN   = 5'd16;
   localparam logic [4:0] OP_OUT  = 5'd17;
   localparam logic [4:0] OP_HALT = 5'd18;

   typedef enum logic [1:0] {S_RUN, S_OUT_WAIT, S_HALT} state_t;

   state_t                 state_q, state_d;
   logic [NBADD-1:0]       pc_q, pc_d;
   logic [NBITS-1:0]       acc_q, acc_d;
   logic [NBADD-1:0]       x_q, x_d;
   logic [NCH*NBITS-1:0]   out_data_q, out_data_d;
   logic [NCH-1:0]         out_valid_q, out_valid_d;

   logic [NBITS-1:0]       mem [DEPTH];
   logic                   mem_we;

   logic [4:0]             opcode;
   logic [NBADD-1:0]       opa;
   logic [NBADD-1:0]       ea;
   logic [CHW-1:0]         ch;
   logic [NBITS-1:0]       rdata;
   logic [NBADD-1:0]       pc_inc;

   assign opcode = imem_data[NBADD+4:NBADD];
   assign opa    = imem_data[NBADD-1:0];
   assign ea     = opa + x_q;
   assign ch     = CHW'(32'(opa) % NCH);
   assign rdata  = mem[ea];
   assign pc_inc = pc_q + NBADD'(1);

   assign imem_addr = pc_q;
   assign acc       = acc_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = (state_q == S_HALT);

   // Decode and execute the current instruction; compute next state and I/O handshakes.
   always_comb begin
      // NOTE: every _d and output gets its hold/idle value first, so no path leaves a latch.
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      x_d         = x_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      mem_we      = 1'b0;
      in_ready    = '0;
      case (state_q)
         S_RUN: begin
            pc_d = pc_inc;
            case (opcode)
               OP_LDI:  acc_d = NBITS'(opa);
               OP_LD:   acc_d = rdata;
               OP_ST:   mem_we = 1'b1;
               OP_ADD:  acc_d = acc_q + rdata;
               OP_SUB:  acc_d = acc_q - rdata;
               OP_AND:  acc_d = acc_q & rdata;
               OP_OR:   acc_d = acc_q | rdata;
               OP_XOR:  acc_d = acc_q ^ rdata;
               OP_SHL:  acc_d = {acc_q[NBITS-2:0], 1'b0};
               OP_SHR:  acc_d = {1'b0, acc_q[NBITS-1:1]};
               OP_JMP:  pc_d = opa;
               OP_JZ:   if (acc_q == '0) pc_d = opa;
               OP_JN:   if (acc_q[NBITS-1]) pc_d = opa;
               OP_SETX: x_d = opa;
               OP_INCX: x_d = x_q + NBADD'(1);
               OP_IN: begin
                  in_ready[ch] = 1'b1;
                  if (in_valid[ch]) acc_d = in_data[ch*NBITS +: NBITS];
                  else              pc_d  = pc_q;
               end
               OP_OUT: begin
                  out_data_d[ch*NBITS +: NBITS] = acc_q;
                  out_valid_d[ch]               = 1'b1;
                  state_d                       = S_OUT_WAIT;
                  pc_d                          = pc_q;
               end
               OP_HALT: begin
                  state_d = S_HALT;
                  pc_d    = pc_q;
               end
               default: ;
            endcase
         end
         S_OUT_WAIT: begin
            // Only one channel is ever valid, so any matching ready completes the transfer.
            if (|(out_valid_q & out_ready)) begin
               out_valid_d = '0;
               pc_d        = pc_inc;
               state_d     = S_RUN;
            end
         end
         default: ;
      endcase
   end

   // Architectural registers and output registers, cleared by asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (!rst_n) begin
         state_q     <= S_RUN;
         pc_q        <= '0;
         acc_q       <= '0;
         x_q         <= '0;
         out_data_q  <= '0;
         out_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         x_q         <= x_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Data RAM write port; reads are asynchronous through rdata.
   always_ff @(posedge clk) begin
      // NOTE: the RAM is deliberately not reset so it maps onto a memory macro rather than flops.
      if (mem_we) mem[ea] <= acc_q;
   end

endmodule

// File: tb/tb_proc_acc_io.sv
// Self-checking bench for proc_acc_io: an instruction-level model runs alongside
// the DUT and is compared every cycle; directed programs add literal expectations.
module tb_proc_acc_io;

   localparam int NBADD = 10;
   localparam int NBITS = 16;
   localparam int NCH   = 2;
   localparam int DEPTH = 1 << NBADD;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic [NBADD-1:0]     imem_addr;
   logic [NBADD+4:0]     imem_data;
   logic [NCH*NBITS-1:0] in_data = '0;
   logic [NCH-1:0]       in_valid = '0;
   logic [NCH-1:0]       in_ready;
   logic [NCH*NBITS-1:0] out_data;
   logic [NCH-1:0]       out_valid;
   logic [NCH-1:0]       out_ready = '0;
   logic [NBITS-1:0]     acc;
   logic                 halted;

   logic [NBADD+4:0]     rom [DEPTH];
   int                   n_checks = 0;
   int                   n_pass = 0;

   // Reference model state
   int                   m_pc, m_acc, m_x, m_wait_ch;
   int                   m_ram [DEPTH];
   int                   m_out_data [NCH];
   bit [NCH-1:0]         m_out_valid;
   bit                   m_halted, m_waiting;

   assign imem_data = rom[imem_addr];

   proc_acc_io #(.NBADD(NBADD), .NBITS(NBITS), .NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .acc(acc), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [NBADD+4:0] ins(input int op, input int a);
      return {5'(op), 10'(a)};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < DEPTH; i++) rom[i] = '0;
   endtask

   task automatic model_reset();
      m_pc = 0; m_acc = 0; m_x = 0; m_wait_ch = 0;
      m_halted = 0; m_waiting = 0; m_out_valid = '0;
      for (int c = 0; c < NCH; c++) m_out_data[c] = 0;
   endtask

   // One clock of the instruction-set behaviour.
   task automatic model_step();
      int op, a, ea, ch, nxt, word;
      if (m_halted) return;
      if (m_waiting) begin
         if (out_ready[m_wait_ch]) begin
            m_out_valid[m_wait_ch] = 1'b0;
            m_waiting = 0;
            m_pc = (m_pc + 1) % DEPTH;
         end
         return;
      end
      op  = int'(rom[m_pc][14:10]);
      a   = int'(rom[m_pc][9:0]);
      ea  = (a + m_x) % DEPTH;
      ch  = a % NCH;
      nxt = (m_pc + 1) % DEPTH;
      case (op)
         1:  m_acc = a;
         2:  m_acc = m_ram[ea];
         3:  m_ram[ea] = m_acc;
         4:  m_acc = (m_acc + m_ram[ea]) & 'hFFFF;
         5:  m_acc = (m_acc - m_ram[ea]) & 'hFFFF;
         6:  m_acc = m_acc & m_ram[ea];
         7:  m_acc = m_acc | m_ram[ea];
         8:  m_acc = m_acc ^ m_ram[ea];
         9:  m_acc = (m_acc * 2) & 'hFFFF;
         10: m_acc = m_acc / 2;
         11: nxt = a;
         12: if (m_acc == 0) nxt = a;
         13: if (m_acc >= 'h8000) nxt = a;
         14: m_x = a;
         15: m_x = (m_x + 1) % DEPTH;
         16: begin
            if (in_valid[ch]) begin
               word  = int'(in_data[ch*NBITS +: NBITS]);
               m_acc = word;
            end else nxt = m_pc;
         end
         17: begin
            m_out_data[ch] = m_acc;
            m_out_valid[ch] = 1'b1;
            m_waiting = 1; m_wait_ch = ch;
            nxt = m_pc;
         end
         18: begin m_halted = 1; nxt = m_pc; end
         default: ;
      endcase
      m_pc = nxt;
   endtask

   // Model advances on every clock edge and follows the asynchronous reset.
   initial begin
      model_reset();
      for (int i = 0; i < DEPTH; i++) m_ram[i] = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Compare process: outputs against the model, away from the active edge.
   initial begin
      logic [NCH-1:0]       e_rdy;
      logic [NCH*NBITS-1:0] e_data;
      int                   op, a;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            e_rdy = '0;
            op = int'(rom[m_pc][14:10]);
            a  = int'(rom[m_pc][9:0]);
            if (!m_halted && !m_waiting && op == 16) e_rdy[a % NCH] = 1'b1;
            for (int c = 0; c < NCH; c++) e_data[c*NBITS +: NBITS] = NBITS'(m_out_data[c]);
            check("cyc_pc",        imem_addr, m_pc);
            check("cyc_acc",       acc,       m_acc);
            check("cyc_halted",    halted,    m_halted);
            check("cyc_in_ready",  in_ready,  e_rdy);
            check("cyc_out_valid", out_valid, m_out_valid);
            check("cyc_out_data",  out_data,  e_data);
         end
      end
   end

   task automatic hold_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      in_valid = '0;
      out_ready = '0;
      clear_rom();
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int arith_exp [6] = '{7, 7, 5, 12, 5, 'hFFFE};
      #1 rst_n = 1'b0;

      // Reset while an OUT is waiting for acceptance
      hold_reset();
      rom[0] = ins(1, 5); rom[1] = ins(17, 0); rom[2] = ins(18, 0);
      release_reset();
      repeat (2) @(negedge clk);
      check("pre_reset_out_valid", out_valid, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 2'b00);
      check("rst_acc",       acc,       16'h0000);
      check("rst_pc",        imem_addr, 10'd0);
      check("rst_halted",    halted,    1'b0);
      check("rst_in_ready",  in_ready,  2'b00);

      // Arithmetic sequence, one result per cycle
      hold_reset();
      rom[0] = ins(1, 7); rom[1] = ins(3, 10); rom[2] = ins(1, 5);
      rom[3] = ins(4, 10); rom[4] = ins(5, 10); rom[5] = ins(5, 10); rom[6] = ins(18, 0);
      release_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("arith_acc", acc, arith_exp[i]);
      end

      // Indexed store wraps the effective address
      hold_reset();
      rom[0] = ins(14, 3); rom[1] = ins(1, 9); rom[2] = ins(3, 1022);
      rom[3] = ins(14, 0); rom[4] = ins(2, 1); rom[5] = ins(18, 0);
      release_reset();
      repeat (5) @(negedge clk);
      check("index_acc", acc, 16'h0009);
      check("index_pc",  imem_addr, 10'd5);

      // IN stalls until its own channel is valid
      hold_reset();
      rom[0] = ins(16, 1); rom[1] = ins(18, 0);
      in_data = {16'h00AB, 16'h5555};
      release_reset();
      #1 check("in_ready_first", in_ready, 2'b10);
      in_valid = 2'b01;
      repeat (5) begin
         @(negedge clk);
         check("in_stall_ready", in_ready, 2'b10);
         check("in_stall_pc",    imem_addr, 10'd0);
         check("in_stall_acc",   acc, 16'h0000);
      end
      in_valid = 2'b10;
      @(negedge clk);
      check("in_take_acc",   acc, 16'h00AB);
      check("in_take_pc",    imem_addr, 10'd1);
      check("in_take_ready", in_ready, 2'b00);
      in_valid = '0;

      // OUT with backpressure, then a second OUT on channel 3 mod 2 = 1
      hold_reset();
      rom[0] = ins(1, 'h34); rom[1] = ins(17, 0); rom[2] = ins(1, 'h56);
      rom[3] = ins(17, 3); rom[4] = ins(18, 0);
      release_reset();
      @(negedge clk);
      check("out_ldi_acc", acc, 16'h0034);
      repeat (3) begin
         @(negedge clk);
         check("out_bp_valid", out_valid, 2'b01);
         check("out_bp_data",  out_data[15:0], 16'h0034);
         check("out_bp_pc",    imem_addr, 10'd1);
      end
      out_ready = 2'b01;
      @(negedge clk);
      check("out_acc_valid", out_valid, 2'b00);
      check("out_acc_pc",    imem_addr, 10'd2);
      out_ready = '0;
      @(negedge clk);
      @(negedge clk);
      check("out_ch1_valid", out_valid, 2'b10);
      check("out_ch1_data",  out_data, 32'h0056_0034);
      out_ready = 2'b01;
      @(negedge clk);
      check("out_wrong_ready_valid", out_valid, 2'b10);
      check("out_wrong_ready_pc",    imem_addr, 10'd3);
      out_ready = 2'b10;
      @(negedge clk);
      check("out_ch1_done_valid", out_valid, 2'b00);
      check("out_ch1_done_pc",    imem_addr, 10'd4);
      check("out_ch1_done_data",  out_data, 32'h0056_0034);
      out_ready = '0;

      // Countdown loop ending in HALT
      hold_reset();
      rom[0] = ins(1, 3); rom[1] = ins(3, 0); rom[2] = ins(1, 1); rom[3] = ins(3, 1);
      rom[4] = ins(2, 0); rom[5] = ins(5, 1); rom[6] = ins(3, 0); rom[7] = ins(12, 9);
      rom[8] = ins(11, 4); rom[9] = ins(18, 0);
      release_reset();
      repeat (40) @(negedge clk);
      check("loop_halted", halted, 1'b1);
      check("loop_pc",     imem_addr, 10'd9);
      check("loop_acc",    acc, 16'h0000);
      check("loop_model_ram0", m_ram[0], 0);

      // Logic ops, shifts, INCX, JN, unused opcode, untaken JZ
      hold_reset();
      rom[0] = ins(1, 'h3C); rom[1] = ins(14, 5); rom[2] = ins(3, 15); rom[3] = ins(1, 'h0F);
      rom[4] = ins(15, 0); rom[5] = ins(6, 14); rom[6] = ins(7, 14); rom[7] = ins(8, 14);
      rom[8] = ins(1, 1); rom[9] = ins(9, 0); rom[10] = ins(10, 0); rom[11] = ins(10, 0);
      rom[12] = ins(1, 1); rom[13] = ins(5, 14); rom[14] = ins(13, 17); rom[15] = ins(1, 'h99);
      rom[16] = ins(18, 0); rom[17] = ins(9, 0); rom[18] = ins(19, 0); rom[19] = ins(12, 22);
      rom[20] = ins(18, 0);
      release_reset();
      repeat (6) @(negedge clk);
      check("mix_and_acc", acc, 16'h000C);
      repeat (19) @(negedge clk);
      check("mix_acc",    acc, 16'hFF8A);
      check("mix_pc",     imem_addr, 10'd20);
      check("mix_halted", halted, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/proc_acc_io.md
# proc_acc_io

Parametrised accumulator processor with an integrated data RAM, index-register addressing and NCH handshaked input/output channels. It replaces the free-running single-port processor top. It adds asynchronous reset, a HALT state, and blocking valid/ready I/O so the processor can sit between streaming blocks. Instruction memory stays external, as a combinational ROM.

## Interface
- NBADD, 10, address width for PC, data RAM (2^NBADD words) and operand field
- NBITS, 16, data/accumulator width
- NCH, 2, number of input and output channels (1..2^NBADD)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  NBADD  instruction address (= PC)
- imem_data  in  NBADD+5  instruction: [NBADD+4:NBADD] opcode, [NBADD-1:0] operand A
- in_data  in  NCH*NBITS  channel c at [c*NBITS +: NBITS]
- in_valid  in  NCH  input word present
- in_ready  out  NCH  processor accepts channel c this cycle
- out_data  out  NCH*NBITS  registered output words
- out_valid  out  NCH  registered, held until accepted
- out_ready  in  NCH  sink accepts
- acc  out  NBITS  accumulator (debug/print)
- halted  out  1  high in HALT state

## Operation
- Registers: PC (NBADD), ACC (NBITS), X (NBADD), state {RUN, OUT_WAIT, HALT}, RAM 2^NBADD x NBITS (sync write, async read, not reset).
- EA = (A + X) mod 2^NBADD. ch = A mod NCH.
- Opcodes: all complete in one RUN cycle and set PC+1 unless noted.
  - 0 NOP.
  - 1 LDI: ACC <= zero-extended A.
  - 2 LD: ACC <= RAM[EA].
  - 3 ST: RAM[EA] <= ACC.
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR: ACC <= ACC op RAM[EA]; ADD/SUB mod 2^NBITS, no flags.
  - 9 SHL, 10 SHR: ACC shifted by 1, logical, zero fill; A ignored.
  - 11 JMP: PC <= A.
  - 12 JZ: PC <= A if ACC==0, else PC+1.
  - 13 JN: PC <= A if ACC[NBITS-1], else PC+1.
  - 14 SETX: X <= A.
  - 15 INCX: X <= X+1 mod 2^NBADD.
  - 16 IN: see below.
  - 17 OUT: see below.
  - 18 HALT: state <= HALT, PC unchanged.
  - 19-31 NOP.
- PC increments wrap mod 2^NBADD.
- IN: in_ready[ch] = 1 combinationally while state==RUN and opcode==IN; all other in_ready bits 0.
  - On the edge with in_valid[ch]: ACC <= in_data[ch], PC+1.
  - Otherwise the processor stalls; PC and ACC hold.
- OUT: in RUN, out_data[ch] <= ACC, out_valid[ch] <= 1, state <= OUT_WAIT, PC holds.
  - In OUT_WAIT, on the edge with out_ready[ch]: out_valid[ch] <= 0, PC+1, state <= RUN.
  - out_data holds its last value after the transfer.
- HALT is left only by reset. imem_data is ignored in HALT.

## Timing
- Reset (async assert, sync-deassert assumed external):
  - PC=0, ACC=0, X=0, state=RUN.
  - out_valid=0, out_data=0, halted=0, in_ready=0 until the first decode.
  - Reset mid-OUT_WAIT drops out_valid immediately.
- Throughput: one instruction per clock except IN (1 + stall cycles) and OUT (minimum 2 cycles: issue + accept).
- imem_addr = PC, combinational from the register. imem_data must be valid within the same cycle.
- ST-then-LD to the same EA on consecutive cycles returns the stored value.
- out_valid[c] never drops without out_ready[c] (except reset). Only one channel is valid at a time.
- in_valid may rise at any cycle. Data is sampled only on the edge where valid&ready.
- acc output is the ACC register, updated on the executing edge.

## Test plan
- Reset: assert rst_n=0 in OUT_WAIT with out_valid[0]=1 -> out_valid=0, acc=0, imem_addr=0, halted=0 without a clock edge.
- Arithmetic: LDI 7; ST 10; LDI 5; ADD 10; SUB 10; SUB 10 -> acc sequence 7,7,5,12,5,0xFFFE (NBITS=16), one per cycle.
- Indexed wrap: SETX 3; LDI 9; ST 1022; SETX 0; LD 1 -> acc=9, since RAM[1] was written via (1022+3) mod 1024.
- IN stall: IN 1 with in_valid=0 for 5 cycles -> in_ready=2'b10, PC frozen. Then in_valid[1]=1 with data 0x00AB -> acc=0x00AB on that edge, PC+1, in_ready drops.
- OUT backpressure: LDI 0x34; OUT 0; out_ready=0 for 3 cycles -> out_valid[0]=1, out_data[0]=0x0034 stable. Then out_ready[0]=1 -> out_valid falls next edge, PC advances; OUT 3 with NCH=2 uses channel 1.
- Loop/halt: LDI 3; ST 0; LDI 1; ST 1; LD 0; SUB 1; ST 0; JZ 9; JMP 4; HALT -> halted=1 after 3 iterations, PC=9 frozen, RAM[0]=0.
